// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding, sizes,
// debug view of the FSM and a one-hot helper.
package mux_rr_arbiter_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    typedef struct packed {
        state_t state;
        logic   hold_at_max;
    } dbg_t;

    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// Combinational rotating priority encoder: searches ptr+1, ptr+2, ptr+3, ptr
// (mod 4) and returns the first asserted request.
module rr_pick4
    import mux_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic             o_any,
    output logic [SEL_W-1:0] o_idx
);

    logic [SEL_W-1:0] w_idx;

    // Walk from the last slot back to the first so the earliest hit wins.
    always_comb begin
        o_any = 1'b0;
        o_idx = i_ptr;
        w_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = i_ptr + k[SEL_W-1:0];
            if (i_req[w_idx]) begin
                o_any = 1'b1;
                o_idx = w_idx;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of a 4:1 bit mux.
// Optional hold timeout is enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  din,
    output logic [NREQ-1:0]  grant,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic             dout,
    output dbg_t             o_dbg
);

    state_t            r_state, w_nxt_state;
    logic [SEL_W-1:0]  r_ptr, w_nxt_ptr;
    logic [CNT_W-1:0]  r_hold, w_nxt_hold;
    logic [NREQ-1:0]   r_grant, w_nxt_grant;
    logic [SEL_W-1:0]  r_sel, w_nxt_sel;
    logic              r_valid, w_nxt_valid;

    logic              w_any;
    logic [SEL_W-1:0]  w_idx;
    logic              w_at_max;
    logic              w_timeout;
    logic              w_release;

    rr_pick4 u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_idx)
    );

    assign w_at_max = (r_hold == CNT_W'(MAX_HOLD));

`ifdef MUX_ARB_TIMEOUT_EN
    // A holder that used its full slot yields; the pick still starts at ptr+1,
    // so a lone requester simply wins again.
    assign w_timeout = w_at_max && (req != '0);
`else
    assign w_timeout = 1'b0;
`endif

    assign w_release = !req[r_sel] || w_timeout;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_ptr;
        w_nxt_hold  = r_hold;
        w_nxt_grant = r_grant;
        w_nxt_sel   = r_sel;
        w_nxt_valid = r_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_nxt_state = ST_GRANT;
                    w_nxt_ptr   = w_idx;
                    w_nxt_sel   = w_idx;
                    w_nxt_grant = onehot(w_idx);
                    w_nxt_valid = 1'b1;
                    w_nxt_hold  = CNT_W'(1);
                end
            end
            ST_GRANT: begin
                if (w_release && w_any) begin
                    w_nxt_ptr   = w_idx;
                    w_nxt_sel   = w_idx;
                    w_nxt_grant = onehot(w_idx);
                    w_nxt_hold  = CNT_W'(1);
                end else if (w_release) begin
                    // sel deliberately keeps its last value while idle.
                    w_nxt_state = ST_IDLE;
                    w_nxt_grant = '0;
                    w_nxt_valid = 1'b0;
                end else if (r_hold != '1) begin
                    w_nxt_hold  = r_hold + CNT_W'(1);
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_grant = '0;
                w_nxt_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= SEL_W'(NREQ - 1);
            r_hold  <= '0;
            r_grant <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_ptr   <= w_nxt_ptr;
            r_hold  <= w_nxt_hold;
            r_grant <= w_nxt_grant;
            r_sel   <= w_nxt_sel;
            r_valid <= w_nxt_valid;
        end
    end

    assign grant = r_grant;
    assign sel   = r_sel;
    assign valid = r_valid;
    assign dout  = r_valid ? din[r_sel] : 1'b0;

    assign o_dbg.state       = r_state;
    assign o_dbg.hold_at_max = w_at_max;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vector table, hand-written
// timeout and async-reset sequences, and random traffic against a reference model.
module tb_mux_rr_arbiter;
    import mux_rr_arbiter_pkg::*;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic       dout;
    dbg_t       dbg;

    int checks;
    int failures;

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .din   (din),
        .grant (grant),
        .sel   (sel),
        .valid (valid),
        .dout  (dout),
        .o_dbg (dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: which requester holds the grant and for how long
    bit m_valid;
    int m_sel;
    int m_last;
    int m_held;

    task automatic model_reset();
        m_valid = 0;
        m_sel   = 0;
        m_last  = 3;
        m_held  = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        bit rel;
        int win;
        bit tmo;
`ifdef MUX_ARB_TIMEOUT_EN
        tmo = (m_held == MAX_HOLD) && (r != 4'b0000);
`else
        tmo = 0;
`endif
        rel = m_valid && (!r[m_sel] || tmo);
        if (!m_valid || rel) begin
            win = -1;
            for (int k = 1; k <= 4; k++) begin
                if (win < 0 && r[(m_last + k) % 4]) win = (m_last + k) % 4;
            end
            if (win >= 0) begin
                m_valid = 1;
                m_sel   = win;
                m_last  = win;
                m_held  = 1;
            end else begin
                m_valid = 0;
            end
        end else if (m_held < CNT_MAX) begin
            m_held = m_held + 1;
        end
    endtask

    // scoreboard
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] eg;
        logic [1:0] es;
        logic       ed;
        eg = 4'b0000;
        es = 2'(m_sel);
        ed = 1'b0;
        if (m_valid) begin
            eg[m_sel] = 1'b1;
            ed = din[m_sel];
        end
        chk({tag, "_grant"}, {4'b0, grant}, {4'b0, eg});
        chk({tag, "_sel"},   {6'b0, sel},   {6'b0, es});
        chk({tag, "_valid"}, {7'b0, valid}, {7'b0, m_valid});
        chk({tag, "_dout"},  {7'b0, dout},  {7'b0, ed});
        chk({tag, "_state"}, {7'b0, dbg.state}, {7'b0, m_valid});
    endtask

    // drivers
    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        din = 4'b0000;
        model_reset();
        #1;
        chk("rst_grant", {4'b0, grant}, 8'h00);
        chk("rst_sel",   {6'b0, sel},   8'h00);
        chk("rst_valid", {7'b0, valid}, 8'h00);
        chk("rst_dout",  {7'b0, dout},  8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] d);
        req = r;
        din = d;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         rst_first;
        logic [3:0] req;
        logic [3:0] din;
        logic [3:0] exp_grant;
        logic [1:0] exp_sel;
        logic       exp_valid;
        logic       exp_dout;
    } vec_t;

    vec_t vecs[21];

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 4'b0000;
        din      = 4'b0000;

        vecs[0]  = '{1'b1, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 4'b0010, 4'b1101, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'b1010, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 4'b1010, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 4'b0101, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
        // all four requesting, each holder drops for one cycle after two grant cycles
        vecs[12] = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 4'b1111, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 4'b1110, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 4'b1111, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 4'b1101, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 4'b1111, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 4'b1011, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[20] = '{1'b0, 4'b0111, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1};

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].rst_first) do_reset();
            step(vecs[i].req, vecs[i].din);
            chk($sformatf("vec%0d_grant", i), {4'b0, grant}, {4'b0, vecs[i].exp_grant});
            chk($sformatf("vec%0d_sel", i),   {6'b0, sel},   {6'b0, vecs[i].exp_sel});
            chk($sformatf("vec%0d_valid", i), {7'b0, valid}, {7'b0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_dout", i),  {7'b0, dout},  {7'b0, vecs[i].exp_dout});
        end

        // two constant requesters: alternate every MAX_HOLD cycles, or never
        do_reset();
        for (int c = 0; c < 5 * MAX_HOLD; c++) begin
            logic [3:0] eg;
            step(4'b0101, 4'b0101);
`ifdef MUX_ARB_TIMEOUT_EN
            eg = ((c / MAX_HOLD) % 2 == 1) ? 4'b0100 : 4'b0001;
`else
            eg = 4'b0001;
`endif
            chk($sformatf("hold%0d_grant", c), {4'b0, grant}, {4'b0, eg});
            chk($sformatf("hold%0d_dout", c), {7'b0, dout}, 8'h01);
        end

        // async reset between edges while granted
        do_reset();
        step(4'b0100, 4'b0100);
        chk("pre_rst_grant", {4'b0, grant}, 8'h04);
        chk("pre_rst_dout", {7'b0, dout}, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_grant", {4'b0, grant}, 8'h00);
        chk("async_rst_sel",   {6'b0, sel},   8'h00);
        chk("async_rst_valid", {7'b0, valid}, 8'h00);
        chk("async_rst_dout",  {7'b0, dout},  8'h00);
        #1;
        rst = 1'b0;
        step(4'b1010, 4'b0010);
        chk("post_rst_grant", {4'b0, grant}, 8'h02);
        chk("post_rst_sel",   {6'b0, sel},   8'h01);
        chk("post_rst_dout",  {7'b0, dout},  8'h01);

        // random traffic with sticky requests so holds and timeouts occur
        do_reset();
        begin
            logic [3:0] cur;
            cur = 4'($urandom_range(0, 15));
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 15) < 3) cur = 4'($urandom_range(0, 15));
                model_step(cur);
                step(cur, 4'($urandom_range(0, 15)));
                check_model($sformatf("rnd%0d", n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
